uart2wifi_core_esp_framer: RTL
==============================

# uart2wifi_core_esp_framer

Downstream stage of the UART receive path. On a `send_buffer` pulse it drains bytes buffered in the RX FIFO and frames them for the ESP Wi-Fi module: it emits the ASCII command `AT+CIPSEND=<n>\r\n`, waits for the ESP's `>` prompt, then streams the `n` payload bytes. All output goes to the ESP-side UART transmitter. It turns raw serial bytes into ESP TCP/UDP sends.

## Interface
Parameters:
- MAX_LEN, 64: maximum payload bytes per send. Must be in the range 1..999.
- CNT_W, 7: width of `fifo_count`.
- PROMPT_TIMEOUT, 1_000_000: number of cycles to wait for `>` before aborting (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-high.
- send_buffer  in  1  single-cycle request to flush the FIFO.
- fifo_empty  in  1  RX FIFO empty.
- fifo_count  in  CNT_W  number of bytes stored in the FIFO.
- fifo_rd  out  1  FIFO pop strobe, one cycle per byte.
- fifo_rdata  in  8  FIFO read data; valid on the cycle after `fifo_rd`.
- tx_ready  in  1  ESP transmitter can accept a byte.
- tx_wr  out  1  byte write strobe to the ESP transmitter.
- tx_data  out  8  byte to transmit; valid while `tx_wr` is high.
- esp_rx_valid  in  1  byte received from the ESP (one-cycle strobe).
- esp_rx_data  in  8  received ESP byte.
- busy  out  1  high from request acceptance until DONE or ERR completes.
- done  out  1  one-cycle pulse when a frame completes.
- error  out  1  one-cycle pulse on prompt timeout.

## Operation
- All outputs reset to 0, and the FSM resets to IDLE.
- **IDLE.** `send_buffer` is accepted only when `fifo_empty`=0. On acceptance, `len = min(fifo_count, MAX_LEN)` is latched into a 10-bit register and `busy` is set.
  - `send_buffer` with an empty FIFO is ignored: no output activity.
  - `send_buffer` while busy is ignored and is not queued.
- **HDR.** Emits the 11 bytes `A T + C I P S E N D =` (0x41 0x54 0x2B 0x43 0x49 0x50 0x53 0x45 0x4E 0x44 0x3D).
- **DIGITS.** Emits the decimal ASCII of `len` with no leading zeros, 1 to 3 bytes (for example, 64 is sent as 0x36 0x34).
- **CRLF.** Emits 0x0D then 0x0A.
- **WAIT_PROMPT.** A timeout counter starts at 0.
  - `esp_rx_valid` with data 0x3E moves to PAYLOAD. Any other ESP byte is ignored.
  - If the counter reaches PROMPT_TIMEOUT-1 with no prompt, go to ERR.
  - ESP bytes arriving in any other state are ignored.
- **PAYLOAD.** For each of the `len` bytes:
  - Pulse `fifo_rd`.
  - Capture `fifo_rdata` on the next cycle.
  - Hold the byte until `tx_ready`, then issue `tx_wr`.
  - A down-counter tracks the remaining bytes; at 0, go to DONE.
- **DONE.** Pulse `done`, clear `busy`, return to IDLE.
- **ERR.** Pulse `error`, clear `busy`, return to IDLE. No FIFO bytes have been consumed at this point.
- FIFO bytes beyond `len` remain in the FIFO for a later request.
- Reset during any state aborts the frame immediately. Any bytes already popped are lost.

## Timing
- `tx_wr` is asserted only in a cycle where `tx_ready` is sampled high.
- There is at most one `tx_wr` per two cycles, which gives the transmitter one cycle to deassert `tx_ready`.
- `tx_data` is registered and is stable in the `tx_wr` cycle.
- Latency from `send_buffer` to the first `tx_wr` (0x41) is 2 cycles when `tx_ready`=1.
- `fifo_rd` is never asserted while `fifo_empty`=1. If the FIFO empties mid-payload, the block stalls until data arrives; the count guarantees this cannot happen with a correct FIFO.
- `done` and `error` pulse 1 cycle after the last `tx_wr` and after the timeout expiry respectively.
- `busy` falls in the same cycle as the `done` or `error` pulse.

## Structure
- Shared package `uart2wifi_core_pkg` holds:
  - the FSM state enum (IDLE, HDR, DIGITS, CRLF, WAIT_PROMPT, PAYLOAD, DONE, ERR);
  - the ASCII constants (CR, LF, PROMPT);
  - the 11-byte header constant array.
- Sub-module `uart2wifi_core_bin2dec`: combinational 10-bit to 3-digit BCD conversion plus a digit count. It is shared later with the status reporter.
- Everything else stays in a single FSM and datapath module.

## Test plan
- FIFO holds 5 bytes 0x77 0x78 0x79 0x7A 0x7B; pulse `send_buffer`; hold `tx_ready`=1; inject `>` after LF.
  - Required bytes: `AT+CIPSEND=5\r\n` then 77 78 79 7A 7B.
  - Exactly 5 `fifo_rd` pulses, one `done` pulse, `busy` low afterwards.
- `fifo_count`=100 with MAX_LEN=64.
  - Required bytes: header `64\r\n`, then 64 payload bytes in FIFO order.
  - 36 bytes remain in the FIFO.
- Empty FIFO plus `send_buffer`: no `tx_wr`, no `busy`, no `done`.
- PROMPT_TIMEOUT=1000 and no `>` sent (only 0x4F 0x4B injected).
  - `error` pulses 1000 cycles after LF.
  - Zero `fifo_rd`; `busy` falls.
- `tx_ready` high for 1 cycle every 868 cycles (115200 baud); second `send_buffer` issued mid-header.
  - Identical byte sequence, with no drops or duplicates.
  - The second request is ignored.
- Assert `rst` after the 3rd payload byte.
  - All outputs go to 0 asynchronously.
  - The next `send_buffer` restarts from the header 0x41.

Source files
------------

// File: rtl/uart2wifi_core_pkg.sv
// Shared definitions for the UART-to-Wi-Fi core: framer FSM states, ASCII
// constants and the fixed "AT+CIPSEND=" command prefix.
package uart2wifi_core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DIGITS,
        CRLF,
        WAIT_PROMPT,
        PAYLOAD,
        DONE,
        ERR
    } framer_state_t;

    // Per-byte sub-sequence of the payload phase: pop, wait for read data,
    // capture it, then hand it to the transmitter.
    typedef enum logic [1:0] {
        PL_READ,
        PL_WAIT,
        PL_CAPTURE,
        PL_SEND
    } payload_step_t;

    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;
    localparam logic [7:0] PROMPT     = 8'h3E;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    localparam int HDR_LEN = 11;

    localparam logic [7:0] HDR_BYTES [HDR_LEN] = '{
        8'h41, 8'h54, 8'h2B, 8'h43, 8'h49, 8'h50,
        8'h53, 8'h45, 8'h4E, 8'h44, 8'h3D
    };

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO | {4'h0, digit};
    endfunction

endpackage

// File: rtl/uart2wifi_core_bin2dec.sv
// Combinational binary-to-BCD converter for values 0..999, with the number of
// significant decimal digits (1..3) for printing without leading zeros.
module uart2wifi_core_bin2dec (
    input  logic [9:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] num_digits
);

    logic [11:0] bcd;

    // Shift-and-add-3: any nibble of 5 or more is corrected before each shift.
    always_comb begin
        bcd = '0;
        for (int i = 9; i >= 0; i--) begin
            if (bcd[3:0] > 4'd4) begin
                bcd[3:0] = bcd[3:0] + 4'd3;
            end
            if (bcd[7:4] > 4'd4) begin
                bcd[7:4] = bcd[7:4] + 4'd3;
            end
            if (bcd[11:8] > 4'd4) begin
                bcd[11:8] = bcd[11:8] + 4'd3;
            end
            bcd = {bcd[10:0], bin[i]};
        end
    end

    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

    always_comb begin
        num_digits = 2'd1;
        if (hundreds != 4'd0) begin
            num_digits = 2'd3;
        end else if (tens != 4'd0) begin
            num_digits = 2'd2;
        end
    end

endmodule

// File: rtl/uart2wifi_core_esp_framer.sv
// Drains the RX FIFO into an ESP "AT+CIPSEND=<n>\r\n" command, waits for the
// ESP '>' prompt and then streams the n payload bytes to the ESP transmitter.
module uart2wifi_core_esp_framer
    import uart2wifi_core_pkg::*;
#(
    parameter int MAX_LEN        = 64,
    parameter int CNT_W          = 7,
    parameter int PROMPT_TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_buffer,
    input  logic             fifo_empty,
    input  logic [CNT_W-1:0] fifo_count,
    output logic             fifo_rd,
    input  logic [7:0]       fifo_rdata,
    input  logic             tx_ready,
    output logic             tx_wr,
    output logic [7:0]       tx_data,
    input  logic             esp_rx_valid,
    input  logic [7:0]       esp_rx_data,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int              TO_W      = $clog2(PROMPT_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(PROMPT_TIMEOUT - 1);
    localparam logic [9:0]      MAX_LEN_W = 10'(MAX_LEN);
    localparam logic [3:0]      HDR_LAST  = 4'(HDR_LEN - 1);

    framer_state_t   state;
    payload_step_t   step;
    logic [9:0]      len_q;
    logic [9:0]      remain_q;
    logic [3:0]      idx_q;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      hold_q;

    logic [9:0]      count_ext;
    logic [9:0]      len_next;
    logic [3:0]      d_hund;
    logic [3:0]      d_tens;
    logic [3:0]      d_ones;
    logic [1:0]      num_digits;
    logic [7:0]      digit_byte;
    logic            tx_go;

    assign count_ext = 10'(fifo_count);
    assign len_next  = (count_ext > MAX_LEN_W) ? MAX_LEN_W : count_ext;

    uart2wifi_core_bin2dec u_bin2dec (
        .bin        (len_q),
        .hundreds   (d_hund),
        .tens       (d_tens),
        .ones       (d_ones),
        .num_digits (num_digits)
    );

    // DIGITS walks idx 0..2 (hundreds, tens, ones), starting past leading zeros.
    always_comb begin
        digit_byte = digit_to_ascii(d_ones);
        case (idx_q[1:0])
            2'd0:    digit_byte = digit_to_ascii(d_hund);
            2'd1:    digit_byte = digit_to_ascii(d_tens);
            default: digit_byte = digit_to_ascii(d_ones);
        endcase
    end

    // Transmit handshake: a byte is written by a one-cycle tx_wr with tx_data
    // registered alongside it; tx_wr is only raised on an edge where tx_ready
    // was high and tx_wr was low, so writes are at least two cycles apart and
    // the transmitter has one cycle to drop tx_ready after accepting a byte.
    assign tx_go = tx_ready && !tx_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= PL_READ;
            len_q    <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            to_cnt   <= '0;
            hold_q   <= '0;
            fifo_rd  <= 1'b0;
            tx_wr    <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            tx_wr   <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;

            case (state)
                IDLE: begin
                    if (send_buffer && !fifo_empty) begin
                        len_q <= len_next;
                        idx_q <= '0;
                        busy  <= 1'b1;
                        state <= HDR;
                    end
                end

                HDR: begin
                    if (tx_go) begin
                        tx_wr   <= 1'b1;
                        tx_data <= HDR_BYTES[idx_q];
                        if (idx_q == HDR_LAST) begin
                            idx_q <= {2'b00, 2'd3 - num_digits};
                            state <= DIGITS;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end

                DIGITS: begin
                    if (tx_go) begin
                        tx_wr   <= 1'b1;
                        tx_data <= digit_byte;
                        if (idx_q == 4'd2) begin
                            idx_q <= '0;
                            state <= CRLF;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end

                CRLF: begin
                    if (tx_go) begin
                        tx_wr <= 1'b1;
                        if (idx_q == 4'd0) begin
                            tx_data <= CR;
                            idx_q   <= 4'd1;
                        end else begin
                            tx_data <= LF;
                            to_cnt  <= '0;
                            state   <= WAIT_PROMPT;
                        end
                    end
                end

                // error/busy change on the expiry edge so the pulse lands one
                // cycle after the counter reaches its last value.
                WAIT_PROMPT: begin
                    if (esp_rx_valid && esp_rx_data == PROMPT) begin
                        remain_q <= len_q;
                        step     <= PL_READ;
                        state    <= (len_q == 10'd0) ? DONE : PAYLOAD;
                    end else if (to_cnt == TO_LAST) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                PAYLOAD: begin
                    case (step)
                        PL_READ: begin
                            if (!fifo_empty) begin
                                fifo_rd <= 1'b1;
                                step    <= PL_WAIT;
                            end
                        end
                        PL_WAIT: begin
                            step <= PL_CAPTURE;
                        end
                        PL_CAPTURE: begin
                            hold_q <= fifo_rdata;
                            step   <= PL_SEND;
                        end
                        default: begin
                            if (tx_go) begin
                                tx_wr    <= 1'b1;
                                tx_data  <= hold_q;
                                remain_q <= remain_q - 10'd1;
                                step     <= PL_READ;
                                if (remain_q == 10'd1) begin
                                    state <= DONE;
                                end
                            end
                        end
                    endcase
                end

                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                ERR: begin
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
